faux_sata_hd_dev: RTL and testbench

//  Behavioural-synthesizable fake SATA device (drive side of the link) for stack simulation.

---
 rtl/sata_prim_pkg.sv | 41 ++++
 rtl/faux_hd_oob.sv | 54 +++++
 rtl/faux_sata_hd_dev.sv | 155 +++++++++++++++
 tb/tb_faux_sata_hd_dev.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/sata_prim_pkg.sv
// SATA primitive encodings, device FSM state type and small decode helpers
// shared by the faux SATA drive model.
package sata_prim_pkg;

  localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] PRIM_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] PRIM_X_RDY = 32'h5757B57C;
  localparam logic [31:0] PRIM_R_RDY = 32'h4A4A957C;
  localparam logic [31:0] PRIM_R_IP  = 32'h5555B57C;
  localparam logic [31:0] PRIM_R_OK  = 32'h3535B57C;
  localparam logic [31:0] PRIM_SOF   = 32'h3737B57C;
  localparam logic [31:0] PRIM_EOF   = 32'hD5D5B57C;
  localparam logic [31:0] PRIM_HOLD  = 32'hD5D5AA7C;
  localparam logic [31:0] PRIM_HOLDA = 32'h9595AA7C;
  localparam logic [31:0] PRIM_CONT  = 32'h9999AA7C;

  localparam logic [3:0] ISK_PRIM = 4'b0001;
  localparam logic [3:0] ISK_DATA = 4'b0000;

  typedef enum logic [3:0] {
    ST_WAIT_COMRESET,
    ST_SEND_COMINIT,
    ST_WAIT_COMWAKE,
    ST_SEND_COMWAKE,
    ST_SEND_ALIGN,
    ST_IDLE,
    ST_RX_RDY,
    ST_RX_DATA,
    ST_RX_WTRM
  } hd_state_e;

  function automatic logic rx_is(input logic [31:0] din, input logic [3:0] isk,
                                 input logic [31:0] prim);
    return (isk == ISK_PRIM) && (din == prim);
  endfunction

  function automatic logic is_link_state(input hd_state_e s);
    return (s == ST_IDLE) || (s == ST_RX_RDY) || (s == ST_RX_DATA) || (s == ST_RX_WTRM);
  endfunction

endpackage

// File: rtl/faux_hd_oob.sv
// OOB responder: times the COMINIT and COMWAKE bursts with one shared
// down-counter; a new COMINIT request always restarts the burst.
module faux_hd_oob #(
  parameter int unsigned COMINIT_LEN = 16,
  parameter int unsigned COMWAKE_LEN = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_cominit_go,
  input  logic i_comwake_go,
  output logic o_comm_reset,
  output logic o_comm_wake,
  output logic o_cominit_done,
  output logic o_comwake_done
);

  localparam int unsigned MAXLEN = (COMINIT_LEN > COMWAKE_LEN) ? COMINIT_LEN : COMWAKE_LEN;
  localparam int unsigned CW     = $clog2(MAXLEN) + 1;

  logic [CW-1:0] r_cnt;
  logic          r_ri_act;
  logic          r_wk_act;
  logic          w_tc;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cnt    <= '0;
      r_ri_act <= 1'b0;
      r_wk_act <= 1'b0;
    end else if (i_cominit_go) begin
      r_cnt    <= CW'(COMINIT_LEN - 1);
      r_ri_act <= 1'b1;
      r_wk_act <= 1'b0;
    end else if (i_comwake_go) begin
      r_cnt    <= CW'(COMWAKE_LEN - 1);
      r_ri_act <= 1'b0;
      r_wk_act <= 1'b1;
    end else if (r_ri_act || r_wk_act) begin
      if (w_tc) begin
        r_ri_act <= 1'b0;
        r_wk_act <= 1'b0;
      end else begin
        r_cnt <= r_cnt - CW'(1);
      end
    end
  end

  assign w_tc           = (r_cnt == '0);
  assign o_comm_reset   = r_ri_act;
  assign o_comm_wake    = r_wk_act;
  assign o_cominit_done = r_ri_act & w_tc;
  assign o_comwake_done = r_wk_act & w_tc;

endmodule

// File: rtl/faux_sata_hd_dev.sv
// Fake SATA drive: OOB answer, ALIGN lock, then FIS reception from the host.
// Define FAUX_HD_ALIGN_INSERT_EN to insert an ALIGN pair every 254 dwords after lock.
//   state          | meaning
//   WAIT_COMRESET  | link down, transmit zeros
//   SEND_COMINIT   | COMINIT burst to host
//   WAIT_COMWAKE   | wait for host COMWAKE
//   SEND_COMWAKE   | COMWAKE burst to host
//   SEND_ALIGN     | transmit ALIGN until host ALIGN with byte lock
//   IDLE           | link up, transmit SYNC
//   RX_RDY         | host X_RDY seen, transmit R_RDY
//   RX_DATA        | inside FIS, transmit R_IP / HOLD / HOLDA
//   RX_WTRM        | FIS ended, transmit R_OK until SYNC
module faux_sata_hd_dev
  import sata_prim_pkg::*;
#(
  parameter int unsigned COMINIT_LEN = 16,
  parameter int unsigned COMWAKE_LEN = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,  // active-low
  input  logic [31:0] i_rx_din,
  input  logic [3:0]  i_rx_isk,
  input  logic        i_rx_is_elec_idle,
  input  logic        i_rx_byte_is_aligned,
  input  logic        i_comm_reset_detect,
  input  logic        i_comm_wake_detect,
  input  logic        i_dbg_hold,
  output logic [31:0] o_tx_dout,
  output logic [3:0]  o_tx_isk,
  output logic        o_tx_comm_reset,
  output logic        o_tx_comm_wake,
  output logic        o_hd_ready,
  output logic [31:0] o_hd_data_to_host
);

  hd_state_e   r_state, w_state_nxt;
  logic        r_rx_hold, r_dbg_hold;
  logic [31:0] r_hd_data;
  logic        w_cominit_go, w_comwake_go, w_cominit_done, w_comwake_done;
  logic        w_rx_prim, w_rx_data, w_ins;
  logic [31:0] w_tx_dout;
  logic        w_tx_prim;

  assign w_rx_prim = (i_rx_isk == ISK_PRIM);
  assign w_rx_data = (i_rx_isk == ISK_DATA);

  faux_hd_oob #(.COMINIT_LEN(COMINIT_LEN), .COMWAKE_LEN(COMWAKE_LEN)) u_oob (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_cominit_go   (w_cominit_go),
    .i_comwake_go   (w_comwake_go),
    .o_comm_reset   (o_tx_comm_reset),
    .o_comm_wake    (o_tx_comm_wake),
    .o_cominit_done (w_cominit_done),
    .o_comwake_done (w_comwake_done)
  );

`ifdef FAUX_HD_ALIGN_INSERT_EN
  logic [7:0] r_ins_cnt;

  // Counts transmitted dwords down from 255; the last two slots carry ALIGN.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)
      r_ins_cnt <= 8'd255;
    else if ((r_state != ST_IDLE) && (w_state_nxt == ST_IDLE))
      r_ins_cnt <= 8'd255;
    else if (is_link_state(r_state))
      r_ins_cnt <= (r_ins_cnt == 8'd0) ? 8'd255 : r_ins_cnt - 8'd1;
  end

  assign w_ins = is_link_state(r_state) && (r_ins_cnt <= 8'd1);
`else
  assign w_ins = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) r_state <= ST_WAIT_COMRESET;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cominit_go = 1'b0;
    w_comwake_go = 1'b0;
    if (i_comm_reset_detect) begin
      w_state_nxt  = ST_SEND_COMINIT;
      w_cominit_go = 1'b1;
    end else if (!w_ins) begin
      case (r_state)
        ST_SEND_COMINIT: if (w_cominit_done) w_state_nxt = ST_WAIT_COMWAKE;
        ST_WAIT_COMWAKE:
          if (i_comm_wake_detect) begin
            w_state_nxt  = ST_SEND_COMWAKE;
            w_comwake_go = 1'b1;
          end
        ST_SEND_COMWAKE: if (w_comwake_done) w_state_nxt = ST_SEND_ALIGN;
        ST_SEND_ALIGN:
          if (!i_rx_is_elec_idle && i_rx_byte_is_aligned && rx_is(i_rx_din, i_rx_isk, PRIM_ALIGN))
            w_state_nxt = ST_IDLE;
        ST_IDLE:    if (rx_is(i_rx_din, i_rx_isk, PRIM_X_RDY)) w_state_nxt = ST_RX_RDY;
        ST_RX_RDY:  if (rx_is(i_rx_din, i_rx_isk, PRIM_SOF))   w_state_nxt = ST_RX_DATA;
        ST_RX_DATA: if (rx_is(i_rx_din, i_rx_isk, PRIM_EOF))   w_state_nxt = ST_RX_WTRM;
        ST_RX_WTRM: if (rx_is(i_rx_din, i_rx_isk, PRIM_SYNC))  w_state_nxt = ST_IDLE;
        default:    w_state_nxt = ST_WAIT_COMRESET;
      endcase
    end
  end

  always_comb begin
    w_tx_dout = '0;
    w_tx_prim = 1'b0;
    case (r_state)
      ST_SEND_ALIGN: begin w_tx_dout = PRIM_ALIGN; w_tx_prim = 1'b1; end
      ST_IDLE:       begin w_tx_dout = PRIM_SYNC;  w_tx_prim = 1'b1; end
      ST_RX_RDY:     begin w_tx_dout = PRIM_R_RDY; w_tx_prim = 1'b1; end
      ST_RX_DATA: begin
        w_tx_prim = 1'b1;
        if (r_rx_hold)       w_tx_dout = PRIM_HOLDA;
        else if (r_dbg_hold) w_tx_dout = PRIM_HOLD;
        else                 w_tx_dout = PRIM_R_IP;
      end
      ST_RX_WTRM:    begin w_tx_dout = PRIM_R_OK;  w_tx_prim = 1'b1; end
      default:       begin w_tx_dout = '0;         w_tx_prim = 1'b0; end
    endcase
    if (w_ins) begin
      w_tx_dout = PRIM_ALIGN;
      w_tx_prim = 1'b1;
    end
  end

  // Host HOLD persists across CONT/ALIGN; any data dword or other primitive ends it.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_rx_hold  <= 1'b0;
      r_dbg_hold <= 1'b0;
      r_hd_data  <= '0;
    end else begin
      r_dbg_hold <= i_dbg_hold;
      if (r_state != ST_RX_DATA)
        r_rx_hold <= 1'b0;
      else if (w_rx_data)
        r_rx_hold <= 1'b0;
      else if (w_rx_prim && (i_rx_din != PRIM_ALIGN) && (i_rx_din != PRIM_CONT))
        r_rx_hold <= (i_rx_din == PRIM_HOLD);
      if ((r_state == ST_RX_DATA) && w_rx_data)
        r_hd_data <= i_rx_din;
    end
  end

  assign o_tx_dout         = w_tx_dout;
  assign o_tx_isk          = w_tx_prim ? ISK_PRIM : ISK_DATA;
  assign o_hd_ready        = is_link_state(r_state);
  assign o_hd_data_to_host = r_hd_data;

endmodule

// File: tb/tb_faux_sata_hd_dev.sv
// Scoreboard bench for faux_sata_hd_dev: stimulus queues the expected outputs
// for each cycle and a monitor compares them after every rising edge.
module tb_faux_sata_hd_dev;

  localparam logic [31:0] T_ALIGN = 32'h7B4A4ABC;
  localparam logic [31:0] T_SYNC  = 32'hB5B5957C;
  localparam logic [31:0] T_X_RDY = 32'h5757B57C;
  localparam logic [31:0] T_R_RDY = 32'h4A4A957C;
  localparam logic [31:0] T_R_IP  = 32'h5555B57C;
  localparam logic [31:0] T_R_OK  = 32'h3535B57C;
  localparam logic [31:0] T_SOF   = 32'h3737B57C;
  localparam logic [31:0] T_EOF   = 32'hD5D5B57C;
  localparam logic [31:0] T_HOLD  = 32'hD5D5AA7C;
  localparam logic [31:0] T_HOLDA = 32'h9595AA7C;
  localparam logic [31:0] T_CONT  = 32'h9999AA7C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] rx_din;
  logic [3:0]  rx_isk;
  logic        rx_is_elec_idle, rx_byte_is_aligned;
  logic        comm_reset_detect, comm_wake_detect, dbg_hold;
  logic [31:0] tx_dout, hd_data_to_host;
  logic [3:0]  tx_isk;
  logic        tx_comm_reset, tx_comm_wake, hd_ready;

  always #5 clk = ~clk;

  faux_sata_hd_dev dut (
    .i_clk                (clk),
    .i_rst                (rst),
    .i_rx_din             (rx_din),
    .i_rx_isk             (rx_isk),
    .i_rx_is_elec_idle    (rx_is_elec_idle),
    .i_rx_byte_is_aligned (rx_byte_is_aligned),
    .i_comm_reset_detect  (comm_reset_detect),
    .i_comm_wake_detect   (comm_wake_detect),
    .i_dbg_hold           (dbg_hold),
    .o_tx_dout            (tx_dout),
    .o_tx_isk             (tx_isk),
    .o_tx_comm_reset      (tx_comm_reset),
    .o_tx_comm_wake       (tx_comm_wake),
    .o_hd_ready           (hd_ready),
    .o_hd_data_to_host    (hd_data_to_host)
  );

  typedef struct {
    string       nm;
    logic [31:0] dout;
    logic        crst;
    logic        cwake;
    logic        rdy;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Monitor: one queued expectation per clock, sampled 1 ns after the edge.
  initial begin
    forever begin
      exp_t        e;
      logic [3:0]  eisk;
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e    = q.pop_front();
        eisk = (e.dout != 32'h0) ? 4'b0001 : 4'b0000;
        n_chk++;
        if (tx_dout !== e.dout || tx_isk !== eisk || tx_comm_reset !== e.crst ||
            tx_comm_wake !== e.cwake || hd_ready !== e.rdy || hd_data_to_host !== e.data) begin
          n_fail++;
          $display("FAIL %s: got dout=%h isk=%b crst=%b cwake=%b rdy=%b data=%h, want dout=%h isk=%b crst=%b cwake=%b rdy=%b data=%h",
                   e.nm, tx_dout, tx_isk, tx_comm_reset, tx_comm_wake, hd_ready, hd_data_to_host,
                   e.dout, eisk, e.crst, e.cwake, e.rdy, e.data);
        end
      end
    end
  end

  task automatic step(input string nm, input logic [31:0] dout, input logic crst,
                      input logic cwake, input logic rdy, input logic [31:0] data);
    exp_t e;
    e.nm = nm; e.dout = dout; e.crst = crst; e.cwake = cwake; e.rdy = rdy; e.data = data;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic rxp(input logic [31:0] d);
    rx_din = d; rx_isk = 4'b0001;
  endtask

  task automatic rxd(input logic [31:0] d);
    rx_din = d; rx_isk = 4'b0000;
  endtask

  // From WAIT_COMRESET to the first IDLE dword (hd_data expected 0 after reset).
  task automatic bring_up();
    rx_is_elec_idle = 1'b1; rx_byte_is_aligned = 1'b0; rxd(32'h0);
    comm_reset_detect = 1'b1;
    step("cominit", 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    comm_reset_detect = 1'b0;
    for (int i = 1; i < 16; i++) step("cominit", 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
    step("cominit_end", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    comm_wake_detect = 1'b1;
    step("comwake", 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    comm_wake_detect = 1'b0;
    for (int i = 1; i < 16; i++) step("comwake", 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    step("send_align", T_ALIGN, 1'b0, 1'b0, 1'b0, 32'h0);
    rxp(T_ALIGN); rx_byte_is_aligned = 1'b1;
    step("align_elec_idle", T_ALIGN, 1'b0, 1'b0, 1'b0, 32'h0);
    rx_is_elec_idle = 1'b0;
    step("idle_entry", T_SYNC, 1'b0, 1'b0, 1'b1, 32'h0);
    rxp(T_SYNC);
  endtask

  initial begin
    logic [31:0] e_idle;
    rst = 1'b0; rxd(32'h0); rx_is_elec_idle = 1'b1; rx_byte_is_aligned = 1'b0;
    comm_reset_detect = 1'b0; comm_wake_detect = 1'b0; dbg_hold = 1'b0;
    @(negedge clk);
    step("reset", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1; comm_wake_detect = 1'b1;
    step("wake_ignored", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    comm_wake_detect = 1'b0;
    step("wait_comreset", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    bring_up();

    // Basic FIS reception
    rxp(T_ALIGN);      step("idle_align_ign", T_SYNC,  1'b0, 1'b0, 1'b1, 32'h0);
    rxp(T_X_RDY);      step("x_rdy",          T_R_RDY, 1'b0, 1'b0, 1'b1, 32'h0);
    rxp(T_CONT);       step("cont",           T_R_RDY, 1'b0, 1'b0, 1'b1, 32'h0);
    rxp(T_SOF);        step("sof",            T_R_IP,  1'b0, 1'b0, 1'b1, 32'h0);
    rxd(32'h00000027); step("data0",          T_R_IP,  1'b0, 1'b0, 1'b1, 32'h00000027);
    rxd(32'hDEADBEEF); step("data1",          T_R_IP,  1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    rxp(T_EOF);        step("eof",            T_R_OK,  1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    rxp(T_SYNC);       step("wtrm_sync",      T_SYNC,  1'b0, 1'b0, 1'b1, 32'hDEADBEEF);

    // Flow control: local throttle, host HOLD, release
    rxp(T_X_RDY);      step("h_x_rdy",        T_R_RDY, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    rxp(T_SOF);        step("h_sof",          T_R_IP,  1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
    rxd(32'h11111111); step("h_data0",        T_R_IP,  1'b0, 1'b0, 1'b1, 32'h11111111);
    dbg_hold = 1'b1;
    rxd(32'h22222222); step("dbg_hold",       T_HOLD,  1'b0, 1'b0, 1'b1, 32'h22222222);
    rxp(T_HOLD);       step("host_hold",      T_HOLDA, 1'b0, 1'b0, 1'b1, 32'h22222222);
    rxp(T_CONT);       step("host_hold_cont", T_HOLDA, 1'b0, 1'b0, 1'b1, 32'h22222222);
    dbg_hold = 1'b0;
    rxd(32'h33333333); step("release",        T_R_IP,  1'b0, 1'b0, 1'b1, 32'h33333333);
    rxp(T_EOF);        step("h_eof",          T_R_OK,  1'b0, 1'b0, 1'b1, 32'h33333333);
    rxp(T_SYNC);       step("h_sync",         T_SYNC,  1'b0, 1'b0, 1'b1, 32'h33333333);

    // Abort mid-FIS, then async reset
    rxp(T_X_RDY);      step("a_x_rdy",        T_R_RDY, 1'b0, 1'b0, 1'b1, 32'h33333333);
    rxp(T_SOF);        step("a_sof",          T_R_IP,  1'b0, 1'b0, 1'b1, 32'h33333333);
    rxd(32'h44444444); step("a_data",         T_R_IP,  1'b0, 1'b0, 1'b1, 32'h44444444);
    rxp(T_SYNC); comm_reset_detect = 1'b1;
    step("abort",      32'h0, 1'b1, 1'b0, 1'b0, 32'h44444444);
    comm_reset_detect = 1'b0;
    step("abort_hold", 32'h0, 1'b1, 1'b0, 1'b0, 32'h44444444);
    rst = 1'b0;
    step("async_rst",  32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    step("async_rst2", 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;

    // Long idle stream after a fresh lock: ALIGN pair only at dwords 255-256 when enabled
    bring_up();
    for (int k = 2; k <= 300; k++) begin
`ifdef FAUX_HD_ALIGN_INSERT_EN
      e_idle = (k == 255 || k == 256) ? T_ALIGN : T_SYNC;
`else
      e_idle = T_SYNC;
`endif
      step("idle_stream", e_idle, 1'b0, 1'b0, 1'b1, 32'h0);
    end

    repeat (3) @(negedge clk);
    if (q.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
